tile_input_conditioner: RTL and testbench
=========================================

# tile_input_conditioner

Input-conditioning stage that sits directly upstream of the tile-matching game FSM (`tilegame`). It synchronizes the raw active-low push buttons and slide switches to `CLOCK_50`, debounces the buttons, and emits single-cycle press pulses. It also encodes the switch bank into a registered tile index with one-hot validity. The game FSM consumes only these clean, clock-aligned pulses and the tile index, never raw `KEY`/`SW`.

## Interface
Parameters:
- `NUM_TILES`, 10: number of slide switches / tiles.
- `NUM_KEYS`, 3: conditioned buttons, mapped to `KEY[3:1]`. `KEY[0]` is not conditioned here.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required to accept a button level change. The top level sets 1_000_000 (20 ms at 50 MHz). Must be ≥ 1.

Ports:
- `CLOCK_50`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high reset.
- `key_n`  in  NUM_KEYS: raw buttons, active-low, asynchronous.
- `sw`  in  NUM_TILES: raw slide switches, asynchronous.
- `key_press`  out  NUM_KEYS: one-cycle pulse per accepted press (high→low of the debounced level).
- `key_held`  out  NUM_KEYS: debounced level, 1 = pressed.
- `tile_idx`  out  $clog2(NUM_TILES): index of the single raised switch; 0 when not valid.
- `tile_valid`  out  1: exactly one switch is up.
- `tile_multi`  out  1: two or more switches are up.

## Operation
- Each `key_n` bit and each `sw` bit passes through a 2-flop synchronizer. On reset, key flops load 1 (released) and switch flops load 0.
- Per-key debounce FSM, states IDLE_UP, CHECK_DOWN, IDLE_DOWN, CHECK_UP:
  - In IDLE_x, a synchronized level differing from the stable level moves to CHECK_x and clears the counter.
  - In CHECK_x, the counter increments each cycle while the level still differs. A return to the stable level goes back to IDLE_x, clears the counter, and emits no pulse.
  - When the counter reaches DEBOUNCE_CYCLES−1 while the level still differs, the stable level flips and the FSM enters the opposite IDLE state.
- `key_press[i]` is registered and high for exactly one cycle on the stable released→pressed transition. Releases produce no pulse.
- Keys are fully independent. Simultaneous presses give simultaneous pulses.
- Counter width is $clog2(DEBOUNCE_CYCLES+1), and the counter saturates (never wraps).
- Switch encoder, computed on synchronized `sw` and registered:
  - popcount==1: `tile_valid`=1 and `tile_idx` = position of the set bit.
  - popcount≥2: `tile_multi`=1, `tile_valid`=0, `tile_idx`=0.
  - popcount==0: all three outputs are 0.
- Reset values: `key_press`=0, `key_held`=0, `tile_idx`=0, `tile_valid`=0, `tile_multi`=0, all FSMs IDLE_UP, counters 0.
- Reset asserted mid-debounce discards the pending change. A key still held after reset release is accepted as a fresh press after the full latency.

## Timing
- Key latency: `key_n[i]` is first sampled low at edge k and held. `key_press[i]` is high for the cycle following edge k+2+DEBOUNCE_CYCLES.
- Any low glitch shorter than DEBOUNCE_CYCLES cycles, after synchronization, yields no pulse and leaves `key_held` unchanged.
- Release latency for `key_held` is the same: k+2+DEBOUNCE_CYCLES.
- Switch latency: an `sw` change sampled at edge k appears on the tile outputs after edge k+3 (2 sync + 1 output register).
- Because the tile outputs settle faster than a key press is accepted, a switch raised in the same cycle as a button press is reflected in `tile_idx` when `key_press` fires.

## Configuration
- `TILE_INPUT_DEBOUNCE_EN` defined: the debounce FSM and counters are built as described.
- Not defined: the FSM and counters are omitted and `key_held` is the synchronized level. `key_press` pulses one cycle on its rising edge, so latency is k+3 and glitches of ≥1 cycle are passed through. `DEBOUNCE_CYCLES` is ignored.
- Switch path is identical in both builds.

## Structure
- Package `tile_input_pkg` holds:
  - `NUM_TILES` default and `TILE_IDX_W`.
  - Key role constants: `KEY_START`=0, `KEY_CONFIRM1`=1, `KEY_CONFIRM2`=2 (indices into `key_press`, corresponding to KEY[1..3]).
  - The debounce state enum.
- One sub-module, `key_debounce`, covers a single key's synchronizer, FSM and pulse register, instantiated NUM_KEYS times in a generate loop. The switch encoder stays inline.

## Test plan
- Reset release, no activity: all outputs 0 for 20 cycles. `key_held`=0 with `key_n`=3'b111.
- `key_n[0]` low at edge 10 for 10 cycles (DEBOUNCE_CYCLES=4): single `key_press[0]` pulse in cycle after edge 16. `key_held[0]` 1 until release accepted. No pulse on release.
- `key_n[1]` low for 3 cycles then high: no `key_press`, `key_held[1]` stays 0. Repeated 2-cycle bounces followed by a steady 8-cycle low: exactly one pulse.
- `sw`=10'b0010000000 → after 3 cycles `tile_idx`=7, `tile_valid`=1. `sw`=10'b0000000011 → `tile_multi`=1, `tile_valid`=0, `tile_idx`=0. `sw`=0 → all 0.
- `key_n[1]` and `key_n[2]` pressed at the same edge: both pulses in the same cycle. `reset` asserted 2 cycles into CHECK_DOWN with key held: no pulse, then a pulse 2+DEBOUNCE_CYCLES cycles after reset deasserts.
- Build without `TILE_INPUT_DEBOUNCE_EN`: 1-cycle-wide low (after sync) produces a `key_press` pulse at k+3.

Source files
------------

// File: rtl/tile_input_pkg.sv
// Shared types and constants for the tile-game input conditioning stage.
package tile_input_pkg;

  localparam int NUM_TILES_DEF = 10;
  localparam int TILE_IDX_W    = $clog2(NUM_TILES_DEF);

  // Bit positions in key_press / key_held (KEY[1..3] on the board)
  localparam int KEY_START    = 0;
  localparam int KEY_CONFIRM1 = 1;
  localparam int KEY_CONFIRM2 = 2;

  typedef enum logic [1:0] {
    IDLE_UP    = 2'd0,
    CHECK_DOWN = 2'd1,
    IDLE_DOWN  = 2'd2,
    CHECK_UP   = 2'd3
  } db_state_e;

endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchronizer, optional debounce FSM, registered press pulse.
// TILE_INPUT_DEBOUNCE_EN selects the debounced build; otherwise the synced level is passed through.
module key_debounce
  import tile_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic key_press,
  output logic key_held
);

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_err
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic r_s1, r_s2;
  logic w_pressed;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= key_n;
      r_s2 <= r_s1;
    end
  end

  assign w_pressed = ~r_s2;

`ifdef TILE_INPUT_DEBOUNCE_EN
  localparam int          CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  db_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_press, w_press_nxt;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= IDLE_UP;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_press <= w_press_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    case (r_state)
      IDLE_UP: if (w_pressed) begin
        w_state_nxt = CHECK_DOWN;
        w_cnt_nxt   = '0;
      end
      CHECK_DOWN: begin
        if (!w_pressed) begin
          w_state_nxt = IDLE_UP;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_DOWN;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      IDLE_DOWN: if (!w_pressed) begin
        w_state_nxt = CHECK_UP;
        w_cnt_nxt   = '0;
      end
      CHECK_UP: begin
        if (w_pressed) begin
          w_state_nxt = IDLE_DOWN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_UP;
          w_cnt_nxt   = '0;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE_UP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign key_press = r_press;
  assign key_held  = (r_state == IDLE_DOWN) || (r_state == CHECK_UP);
`else
  // Extra level stage keeps the press pulse at k+3, one edge behind key_held.
  logic r_held, r_held_d, r_press;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_held   <= 1'b0;
      r_held_d <= 1'b0;
      r_press  <= 1'b0;
    end else begin
      r_held   <= w_pressed;
      r_held_d <= r_held;
      r_press  <= r_held & ~r_held_d;
    end
  end

  assign key_press = r_press;
  assign key_held  = r_held;
`endif

endmodule

// File: rtl/tile_input_conditioner.sv
// Conditions raw KEY/SW for the tile game: per-key debounce + press pulses, registered switch encoder.
// Build option: TILE_INPUT_DEBOUNCE_EN enables the debounce FSMs inside key_debounce.
module tile_input_conditioner
  import tile_input_pkg::*;
#(
  parameter int NUM_TILES       = NUM_TILES_DEF,
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic [NUM_KEYS-1:0]          key_n,
  input  logic [NUM_TILES-1:0]         sw,
  output logic [NUM_KEYS-1:0]          key_press,
  output logic [NUM_KEYS-1:0]          key_held,
  output logic [$clog2(NUM_TILES)-1:0] tile_idx,
  output logic                         tile_valid,
  output logic                         tile_multi
);

  localparam int IDX_W = $clog2(NUM_TILES);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .key_n    (key_n[g]),
      .key_press(key_press[g]),
      .key_held (key_held[g])
    );
  end

  logic [NUM_TILES-1:0] r_sw_s1, r_sw_s2;
  logic [IDX_W-1:0]     r_idx, w_idx;
  logic                 r_valid, r_multi, w_any, w_one;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      r_idx   <= w_one ? w_idx : '0;
      r_valid <= w_one;
      r_multi <= w_any & ~w_one;
    end
  end

  // Clearing the lowest set bit leaves zero only when exactly one bit was up.
  assign w_any = |r_sw_s2;
  assign w_one = w_any && ((r_sw_s2 & (r_sw_s2 - 1'b1)) == '0);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_TILES; i++)
      if (r_sw_s2[i]) w_idx = IDX_W'(i);
  end

  assign tile_idx   = r_idx;
  assign tile_valid = r_valid;
  assign tile_multi = r_multi;

endmodule

// File: tb/tb_tile_input_conditioner.sv
// Directed bench for tile_input_conditioner; expectations follow the build (TILE_INPUT_DEBOUNCE_EN or not).
module tb_tile_input_conditioner;

`ifdef TILE_INPUT_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  localparam int D   = 4;
  localparam int LAT = DB_EN ? 2 + D : 3;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [2:0] key_n;
  logic [9:0] sw;
  logic [2:0] key_press, key_held;
  logic [3:0] tile_idx;
  logic       tile_valid, tile_multi;

  int n_chk = 0;
  int n_err = 0;
  int np[3], first[3], held_seen[3];

  tile_input_conditioner #(
    .NUM_TILES(10), .NUM_KEYS(3), .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .key_n     (key_n),
    .sw        (sw),
    .key_press (key_press),
    .key_held  (key_held),
    .tile_idx  (tile_idx),
    .tile_valid(tile_valid),
    .tile_multi(tile_multi)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // pat[t]=1 drives the masked keys pressed into edge t; records pulses per key.
  task automatic run_pat(input logic [2:0] mask, input logic [63:0] pat, input int n);
    for (int k = 0; k < 3; k++) begin
      np[k] = 0; first[k] = -1; held_seen[k] = 0;
    end
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < 3; k++)
        if (mask[k]) key_n[k] = ~pat[t];
      tick();
      for (int k = 0; k < 3; k++) begin
        if (key_press[k]) begin
          np[k]++;
          if (first[k] < 0) first[k] = t;
        end
        if (key_held[k]) held_seen[k] = 1;
      end
    end
    key_n = 3'b111;
    idle(12);
  endtask

  task automatic sw_step(input logic [9:0] v, input string tag,
                         input int o_idx, input int o_val, input int o_mul,
                         input int e_idx, input int e_val, input int e_mul);
    sw = v;
    idle(2);
    chk({tag, "_old_idx"}, tile_idx, o_idx);
    chk({tag, "_old_valid"}, tile_valid, o_val);
    chk({tag, "_old_multi"}, tile_multi, o_mul);
    idle(2);
    chk({tag, "_idx"}, tile_idx, e_idx);
    chk({tag, "_valid"}, tile_valid, e_val);
    chk({tag, "_multi"}, tile_multi, e_mul);
  endtask

  initial begin
    int busy, pre, dur;
    reset = 1'b1;
    key_n = 3'b111;
    sw    = '0;
    idle(3);
    reset = 1'b0;

    busy = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (key_press != 0 || key_held != 0 || tile_idx != 0 || tile_valid || tile_multi) busy++;
    end
    chk("reset_quiet_cycles", busy, 0);
    chk("reset_key_held", key_held, 0);

    // Steady 10-cycle press on key0
    run_pat(3'b001, 64'h3FF, 24);
    chk("press0_count", np[0], 1);
    chk("press0_latency", first[0], LAT);
    chk("press0_held_seen", held_seen[0], 1);
    chk("press0_held_after", key_held[0], 0);
    chk("press0_other_keys", np[1] + np[2], 0);

    // 3-cycle glitch on key1
    run_pat(3'b010, 64'h7, 12);
    chk("glitch3_count", np[1], DB_EN ? 0 : 1);
    chk("glitch3_held", held_seen[1], DB_EN ? 0 : 1);

    // 1-cycle glitch on key0
    run_pat(3'b001, 64'h1, 10);
    chk("glitch1_count", np[0], DB_EN ? 0 : 1);
    if (!DB_EN) chk("glitch1_latency", first[0], 3);

    // Three 2-cycle bounces then 8 steady low cycles starting at t=12
    run_pat(3'b100, 64'h000F_F333, 36);
    chk("bounce_count", np[2], DB_EN ? 1 : 4);
    chk("bounce_first", first[2], DB_EN ? 12 + LAT : LAT);

    // Simultaneous press on key1 and key2
    run_pat(3'b110, 64'h3FF, 20);
    chk("simul_k1_latency", first[1], LAT);
    chk("simul_k2_latency", first[2], LAT);
    chk("simul_k1_count", np[1], 1);
    chk("simul_k2_count", np[2], 1);
    chk("simul_k0_count", np[0], 0);

    // Switch encoder
    sw_step(10'b0010000000, "sw_bit7", 0, 0, 0, 7, 1, 0);
    sw_step(10'b0000000011, "sw_two",  7, 1, 0, 0, 0, 1);
    sw_step(10'b1000000000, "sw_bit9", 0, 0, 1, 9, 1, 0);
    sw_step(10'b0000000001, "sw_bit0", 9, 1, 0, 0, 1, 0);
    sw_step(10'b0000000000, "sw_none", 0, 1, 0, 0, 0, 0);

    // Reset two cycles into CHECK_DOWN with key0 held throughout
    key_n[0] = 1'b0;
    pre = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (key_press[0]) pre++;
    end
    chk("rst_pre_pulse", pre, DB_EN ? 0 : 1);
    reset = 1'b1;
    dur = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (key_press[0] || key_held[0]) dur++;
    end
    chk("rst_during_quiet", dur, 0);
    reset = 1'b0;
    first[0] = -1;
    np[0] = 0;
    for (int t = 0; t < 16; t++) begin
      tick();
      if (key_press[0]) begin
        np[0]++;
        if (first[0] < 0) first[0] = t;
      end
    end
    chk("rst_fresh_latency", first[0], LAT);
    chk("rst_fresh_count", np[0], 1);
    chk("rst_fresh_held", key_held[0], 1);
    key_n = 3'b111;
    idle(12);
    chk("final_held", key_held, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
